// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
//
// Purpose
//   Read-side companion to a register file with a combinational read port.
//   A Start request walks the read address from FIRST_ADDR to LAST_ADDR and
//   streams every {address, data} pair out over a valid/ready port. It is
//   meant for debug dumps and bench self-checks.
//
// Stream handshake
//   A beat is transferred on any posedge where OutValid & OutReady. Once
//   OutValid is high it stays high, with OutAdd/OutData stable, until that
//   transfer happens. OutValid never depends combinationally on OutReady.
//
// Ports
//   clk       in   1         single clock, all state updates on posedge
//   Reset     in   1         asynchronous active-low reset
//   Start     in   1         dump request, sampled only while idle
//   Busy      out  1         dump in progress (from the cycle after Start to Done)
//   Done      out  1         one-cycle pulse after the final beat is taken
//   RdAdd     out  ADDR_W    register-file read address
//   RdData    in   DATA_W    combinational read data for RdAdd
//   OutValid  out  1         OutAdd/OutData hold a valid beat
//   OutReady  in   1         consumer ready
//   OutAdd    out  ADDR_W    address of the current beat
//   OutData   out  DATA_W    data of the current beat
//   BeatCnt   out  ADDR_W+1  beats emitted in the current/last dump
//   DbgState  out  2         current FSM state (0 IDLE, 1 READ, 2 DRAIN, 3 FINISH)
//
// Build option
//   REGFILE_DUMP_SKIP_ZERO_EN : registers that read as zero are walked past
//   without emitting a beat.
// ---------------------------------------------------------------------------
module regfile_dump_reader #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int FIRST_ADDR = 0,
   parameter int LAST_ADDR  = 31
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              Start,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] RdAdd,
   input  logic [DATA_W-1:0] RdData,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [ADDR_W-1:0] OutAdd,
   output logic [DATA_W-1:0] OutData,
   output logic [ADDR_W:0]   BeatCnt,
   output logic [1:0]        DbgState
);

   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_add_q, rd_add_d;
   logic                out_valid_q, out_valid_d;
   logic [ADDR_W-1:0]   out_add_q, out_add_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [ADDR_W:0]     beat_cnt_q, beat_cnt_d;

   // The output register can take a new beat when it is empty or its
   // current beat is being taken on this edge.
   logic load;
   // A load-eligible cycle that actually produces a beat.
   logic take_beat;

   assign load = !out_valid_q || OutReady;

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
   assign take_beat = load && (RdData != '0);
`else
   assign take_beat = load;
`endif

   // State register
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= S_IDLE;
         rd_add_q    <= '0;
         out_valid_q <= 1'b0;
         out_add_q   <= '0;
         out_data_q  <= '0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         rd_add_q    <= rd_add_d;
         out_valid_q <= out_valid_d;
         out_add_q   <= out_add_d;
         out_data_q  <= out_data_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      rd_add_d    = rd_add_q;
      out_valid_d = out_valid_q;
      out_add_d   = out_add_q;
      out_data_d  = out_data_q;
      beat_cnt_d  = beat_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               rd_add_d   = FIRST_A;
               beat_cnt_d = '0;
               state_d    = S_READ;
            end
         end

         S_READ: begin
            if (load) begin
               // On a skipped address the previous beat (if any) is being
               // taken this edge, so the register simply empties.
               out_valid_d = take_beat;
               if (take_beat) begin
                  out_add_d  = rd_add_q;
                  out_data_d = RdData;
                  beat_cnt_d = beat_cnt_q + (ADDR_W+1)'(1);
               end
               // Stop at LAST_A rather than incrementing, so the address
               // never wraps even when LAST_A is the top of the range.
               if (rd_add_q == LAST_A) begin
                  state_d = S_DRAIN;
               end else begin
                  rd_add_d = rd_add_q + ADDR_W'(1);
               end
            end
         end

         S_DRAIN: begin
            if (load) begin
               out_valid_d = 1'b0;
               state_d     = S_FINISH;
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      Busy     = (state_q != S_IDLE);
      Done     = (state_q == S_FINISH);
      RdAdd    = rd_add_q;
      OutValid = out_valid_q;
      OutAdd   = out_add_q;
      OutData  = out_data_q;
      BeatCnt  = beat_cnt_q;
      DbgState = state_q;
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Bench for regfile_dump_reader. Holds a register-file model whose read port
// is combinational. Instance A uses the full 0..31 range; instance B uses a
// single-address range at 31. Expected beats are pushed when a dump is
// started and popped as the consumer takes them.
// ---------------------------------------------------------------------------
module tb_regfile_dump_reader;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int EW = AW + DW;

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // ---------------- register-file model ----------------
   logic [DW-1:0] regs [32];

   // ---------------- instance A (0..31) ----------------
   logic          start_a, out_ready_a;
   logic          busy_a, done_a, out_valid_a;
   logic [AW-1:0] rd_add_a, out_add_a;
   logic [DW-1:0] rd_data_a, out_data_a;
   logic [AW:0]   beat_cnt_a;
   logic [1:0]    dbg_a;

   assign rd_data_a = regs[rd_add_a];

   regfile_dump_reader #(
      .ADDR_W(AW), .DATA_W(DW), .FIRST_ADDR(0), .LAST_ADDR(31)
   ) dut_a (
      .clk(clk), .Reset(rst_n), .Start(start_a), .Busy(busy_a), .Done(done_a),
      .RdAdd(rd_add_a), .RdData(rd_data_a), .OutValid(out_valid_a),
      .OutReady(out_ready_a), .OutAdd(out_add_a), .OutData(out_data_a),
      .BeatCnt(beat_cnt_a), .DbgState(dbg_a)
   );

   // ---------------- instance B (31..31) ----------------
   logic          start_b, out_ready_b;
   logic          busy_b, done_b, out_valid_b;
   logic [AW-1:0] rd_add_b, out_add_b;
   logic [DW-1:0] rd_data_b, out_data_b;
   logic [AW:0]   beat_cnt_b;
   logic [1:0]    dbg_b;

   assign rd_data_b = regs[rd_add_b];

   regfile_dump_reader #(
      .ADDR_W(AW), .DATA_W(DW), .FIRST_ADDR(31), .LAST_ADDR(31)
   ) dut_b (
      .clk(clk), .Reset(rst_n), .Start(start_b), .Busy(busy_b), .Done(done_b),
      .RdAdd(rd_add_b), .RdData(rd_data_b), .OutValid(out_valid_b),
      .OutReady(out_ready_b), .OutAdd(out_add_b), .OutData(out_data_b),
      .BeatCnt(beat_cnt_b), .DbgState(dbg_b)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int            checks   = 0;
   int            failures = 0;
   int            beats;
   int            done_cnt;
   int            tick_cnt = 0;
   int            first_acc;
   int            last_acc;
   bit            hold_prev;
   logic [EW-1:0] hold_val;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Consumer-side monitor for instance A, run at each negedge.
   task automatic monitor();
      logic [EW-1:0] got;
      logic [EW-1:0] e;
      got = {out_add_a, out_data_a};
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("stall_valid", 64'(out_valid_a), 64'd1);
            chk("stall_stable", 64'(got), 64'(hold_val));
         end
         if (done_a) done_cnt++;
         if (out_valid_a && out_ready_a) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $error("FAIL extra_beat observed=%0h expected=none", got);
            end else begin
               e = exp_q.pop_front();
               chk("beat", 64'(got), 64'(e));
            end
            beats++;
            if (beats == 1) first_acc = tick_cnt;
            last_acc  = tick_cnt;
            hold_prev = 1'b0;
         end else if (out_valid_a) begin
            hold_prev = 1'b1;
            hold_val  = got;
         end else begin
            hold_prev = 1'b0;
         end
      end
   endtask

   // One clock: monitor at negedge, then return just after the posedge.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      tick_cnt++;
   endtask

   // Push the beats a full dump of the current file contents should produce.
   function automatic int push_dump();
      int n;
      n = 0;
      for (int a = 0; a < 32; a++) begin
         if (!SKIP || regs[a] != '0) begin
            exp_q.push_back({5'(a), regs[a]});
            n++;
         end
      end
      return n;
   endfunction

   task automatic chk_reset_a(input string tag);
      chk({tag, "_busy"},     64'(busy_a),      64'd0);
      chk({tag, "_done"},     64'(done_a),      64'd0);
      chk({tag, "_valid"},    64'(out_valid_a), 64'd0);
      chk({tag, "_rdadd"},    64'(rd_add_a),    64'd0);
      chk({tag, "_outadd"},   64'(out_add_a),   64'd0);
      chk({tag, "_outdata"},  64'(out_data_a),  64'd0);
      chk({tag, "_beatcnt"},  64'(beat_cnt_a),  64'd0);
   endtask

   task automatic fill_scenario();
      for (int a = 0; a < 32; a++) regs[a] = '0;
      regs[1] = 32'd15;
      regs[2] = 32'd423;
      regs[3] = 32'd43;
      regs[4] = 32'd23;
      regs[5] = 32'd3;
      regs[6] = 32'd67;
   endtask

   // Full dump on instance A. toggle: OutReady follows 1,0,0,1.
   // restart_at >= 0: Start is raised again once that many beats are taken.
   task automatic run_dump(input bit toggle, input int restart_at);
      int         n;
      int         span;
      bit         seen;
      logic [3:0] pat;
      pat      = 4'b1001;
      n        = push_dump();
      beats    = 0;
      done_cnt = 0;
      out_ready_a = 1'b1;
      start_a     = 1'b1;
      tick();
      start_a = 1'b0;
      chk("busy_after_start", 64'(busy_a),     64'd1);
      chk("rdadd_first",      64'(rd_add_a),   64'd0);
      chk("beatcnt_clr",      64'(beat_cnt_a), 64'd0);
      chk("valid_not_yet",    64'(out_valid_a), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (toggle) out_ready_a = pat[i % 4];
         start_a = (restart_at >= 0) && (beats == restart_at);
         tick();
         if (done_a) seen = 1'b1;
      end
      start_a     = 1'b0;
      out_ready_a = 1'b1;
      chk("done_seen", 64'(seen), 64'd1);
      tick();
      tick();
      tick();
      span = (beats == 0) ? 0 : (last_acc - first_acc + 1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("beat_total",  64'(beats),        64'(n));
      chk("done_once",   64'(done_cnt),     64'd1);
      chk("beat_cnt",    64'(beat_cnt_a),   64'(n));
      chk("busy_end",    64'(busy_a),       64'd0);
      if (!toggle) chk("consecutive", 64'(span), 64'(n));
      exp_q.delete();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bit found;
      rst_n       = 1'b0;
      start_a     = 1'b0;
      out_ready_a = 1'b0;
      start_b     = 1'b0;
      out_ready_b = 1'b1;
      beats       = 0;
      done_cnt    = 0;
      first_acc   = 0;
      last_acc    = 0;
      hold_prev   = 1'b0;
      hold_val    = '0;
      fill_scenario();

      #3;
      chk_reset_a("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Scenario 1: plain dump, consumer always ready.
      run_dump(1'b0, -1);

      // Scenario 2: consumer ready pattern 1,0,0,1.
      run_dump(1'b1, -1);

      // Scenario 3: reset in the middle of a dump.
      void'(push_dump());
      beats       = 0;
      done_cnt    = 0;
      out_ready_a = 1'b1;
      start_a     = 1'b1;
      tick();
      start_a = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (rd_add_a == 5'd11) found = 1'b1;
      end
      chk("abort_point_reached", 64'(found), 64'd1);
      chk("out_add_at_abort", 64'(out_add_a), SKIP ? 64'd6 : 64'd10);
      rst_n = 1'b0;
      #1;
      chk_reset_a("abort");
      exp_q.delete();
      done_cnt = 0;
      tick();
      tick();
      tick();
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_idle",    64'(dbg_a),    64'd0);
      rst_n = 1'b1;
      tick();
      run_dump(1'b0, -1);

      // Scenario 4: Start pulsed again during the dump.
      run_dump(1'b0, 5);

      // Scenario 5: single-address range at the top of the address space.
      regs[31] = 32'hDEADBEEF;
      start_b  = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_rdadd",   64'(rd_add_b),   64'd31);
      chk("b_busy",    64'(busy_b),     64'd1);
      tick();
      chk("b_valid",   64'(out_valid_b), 64'd1);
      chk("b_outadd",  64'(out_add_b),   64'd31);
      chk("b_outdata", 64'(out_data_b),  64'hDEADBEEF);
      chk("b_beatcnt", 64'(beat_cnt_b),  64'd1);
      chk("b_rdhold",  64'(rd_add_b),    64'd31);
      tick();
      chk("b_done",      64'(done_b),      64'd1);
      chk("b_valid_off", 64'(out_valid_b), 64'd0);
      tick();
      chk("b_done_pulse", 64'(done_b), 64'd0);
      chk("b_busy_end",   64'(busy_b), 64'd0);
      chk("b_rdadd_end",  64'(rd_add_b), 64'd31);
      chk("b_beatcnt_end", 64'(beat_cnt_b), 64'd1);

      // Scenario 6: all-zero register file.
      for (int a = 0; a < 32; a++) regs[a] = '0;
      run_dump(1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
